key_debounce: RTL and testbench

- Multi-channel key conditioning stage sitting directly upstream of the board LED/key logic.
- Synchronises raw active-low push-button inputs, debounces each channel independently with a per-key state machine, and emits a clean level plus single-cycle press and release pulses.
- Replaces ad-hoc periodic sampling with deterministic, glitch-free edge events for downstream LED toggle/pattern logic.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce_ch.sv | 182 ++++++++++++++++++
 rtl/key_debounce.sv | 34 +++
 tb/tb_key_debounce.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the key debounce block: channel state
// encoding, 50 MHz timing defaults and the counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        S_UP     = 2'd0,
        S_DN_CHK = 2'd1,
        S_DOWN   = 2'd2,
        S_UP_CHK = 2'd3
    } key_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEF_LONG_CYCLES     = 32'd50000000;

    // Wide enough to hold every count value 0 .. max(a,b)-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 32'd2) ? 32'd1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, registered level/pulses.
// Optional long-press detection is built when KEY_LONGPRESS_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

    logic [1:0]    sync_r;
    logic          raw_n_s;
    key_state_e    state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          level_r, press_r, release_r;
    logic          level_nxt_s, press_nxt_s, release_nxt_s;

    assign raw_n_s = sync_r[1];

    // Two-stage synchroniser; idles released (1) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_in};
        end
    end

    // State, qualification counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_UP;
            cnt_r     <= {CW{1'b0}};
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    // Next state: any disagreement during a check phase restarts from zero.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = {CW{1'b0}};
        case (state_r)
            S_UP: begin
                if (!raw_n_s) begin
                    state_nxt_s = S_DN_CHK;
                end else begin
                    state_nxt_s = S_UP;
                end
            end
            S_DN_CHK: begin
                if (raw_n_s) begin
                    state_nxt_s = S_UP;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s = S_DOWN;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            S_DOWN: begin
                if (raw_n_s) begin
                    state_nxt_s = S_UP_CHK;
                end else begin
                    state_nxt_s = S_DOWN;
                end
            end
            S_UP_CHK: begin
                if (!raw_n_s) begin
                    state_nxt_s = S_DOWN;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s = S_UP;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = S_UP;
            end
        endcase
    end

    // Output decode: pulses fire on the qualifying edge only.
    always_comb begin
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            S_DN_CHK: begin
                if (!raw_n_s && (cnt_r == DEB_LAST)) begin
                    press_nxt_s = 1'b1;
                end else begin
                    press_nxt_s = 1'b0;
                end
            end
            S_UP_CHK: begin
                if (raw_n_s && (cnt_r == DEB_LAST)) begin
                    release_nxt_s = 1'b1;
                end else begin
                    release_nxt_s = 1'b0;
                end
            end
            default: begin
                press_nxt_s   = 1'b0;
                release_nxt_s = 1'b0;
            end
        endcase
        if (press_nxt_s) begin
            level_nxt_s = 1'b1;
        end else if (release_nxt_s) begin
            level_nxt_s = 1'b0;
        end else begin
            level_nxt_s = level_r;
        end
    end

    assign key_level   = level_r;
    assign key_press   = press_r;
    assign key_release = release_r;

`ifdef KEY_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 32'd1);

    logic [CW-1:0] long_cnt_r, long_cnt_nxt_s;
    logic          long_fired_r, long_fired_nxt_s;
    logic          long_r, long_nxt_s;

    // Long-press counter: runs only while settled in S_DOWN, fires once per press.
    always_comb begin
        long_cnt_nxt_s   = {CW{1'b0}};
        long_fired_nxt_s = 1'b0;
        long_nxt_s       = 1'b0;
        if ((state_r == S_DOWN) && !raw_n_s) begin
            long_fired_nxt_s = long_fired_r;
            long_cnt_nxt_s   = long_cnt_r;
            if (long_fired_r) begin
                long_nxt_s = 1'b0;
            end else if (long_cnt_r == LONG_LAST) begin
                long_nxt_s       = 1'b1;
                long_fired_nxt_s = 1'b1;
            end else begin
                long_cnt_nxt_s = long_cnt_r + CW'(1);
            end
        end else begin
            long_nxt_s = 1'b0;
        end
    end

    // Long-press registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_r   <= {CW{1'b0}};
            long_fired_r <= 1'b0;
            long_r       <= 1'b0;
        end else begin
            long_cnt_r   <= long_cnt_nxt_s;
            long_fired_r <= long_fired_nxt_s;
            long_r       <= long_nxt_s;
        end
    end

    assign key_long = long_r;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: NUM_KEYS independent debounce channels.
// Define KEY_LONGPRESS_EN to build per-channel long-press detection.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 32'd4,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_in      (key_in[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (DEBOUNCE_CYCLES=8, LONG_CYCLES=40) against a
// run-length reference model; key_long expectations follow KEY_LONGPRESS_EN.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int D  = 8;
    localparam int L  = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = 4'hF;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    int errors = 0;
    int checks = 0;

    // Reference model: raw pipeline plus run length of disagreement with level
    logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
    int            m_run [NK];
    int            m_hold [NK];
    bit            m_fired [NK];

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_level = 4'h0; m_press = 4'h0; m_rel = 4'h0; m_long = 4'h0;
        for (int i = 0; i < NK; i++) begin
            m_run[i] = 0; m_hold[i] = 0; m_fired[i] = 1'b0;
        end
    endtask

    // A change is accepted once the raw level has disagreed for D+1 straight edges.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NK; i++) begin
                bit pr;
                pr = !m_s2[i];
                m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
                if (pr != m_level[i]) begin
                    m_run[i]++;
                    m_hold[i] = 0;
                    m_fired[i] = 1'b0;
                    if (m_run[i] == D + 1) begin
                        m_level[i] = pr;
                        m_press[i] = pr;
                        m_rel[i]   = !pr;
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                    if (m_level[i]) begin
                        m_hold[i]++;
`ifdef KEY_LONGPRESS_EN
                        if (m_hold[i] == L && !m_fired[i]) begin
                            m_long[i]  = 1'b1;
                            m_fired[i] = 1'b1;
                        end
`endif
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = key_in[i];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) tick();
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0000", {key_level, key_press, key_release, key_long});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: got %h expected 0000", k, {key_level, key_press, key_release, key_long});
            end
        end
    endtask

    task automatic test_press();
        key_in[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL press_model cyc=%0d: got %h expected %h", k,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (key_press !== ((k == 11) ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL press_latency cyc=%0d: got %b expected %b", k, key_press,
                             (k == 11) ? 4'b0001 : 4'b0000);
                end
            end
        end
        checks++;
        if (key_level !== 4'b0001) begin
            errors++;
            $display("FAIL press_level: got %b expected 0001", key_level);
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        int releases = 0;
        for (int c = 0; c < 100; c++) begin
            if (c < 30)       key_in[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else if (c < 50)  key_in[1] = 1'b0;
            else if (c < 80)  key_in[1] = ((c / 3) % 2 == 0) ? 1'b1 : 1'b0;
            else              key_in[1] = 1'b1;
            tick();
            presses  += int'(key_press[1]);
            releases += int'(key_release[1]);
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d: got %h expected %h", c,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
            if (c == 29 || c == 40) begin
                checks++;
                if (presses !== ((c == 40) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL bounce_press_count cyc=%0d: got %0d expected %0d", c, presses, (c == 40) ? 1 : 0);
                end
            end
        end
        checks++;
        if (presses !== 1 || releases !== 1) begin
            errors++;
            $display("FAIL bounce_counts: got press=%0d release=%0d expected 1/1", presses, releases);
        end
    endtask

    task automatic test_simultaneous();
        key_in[3:2] = 2'b00;
        for (int k = 1; k <= 30; k++) begin
            if (k == 15) key_in[3:2] = 2'b11;
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL simul_model cyc=%0d: got %h expected %h", k,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
            if (k == 11 || k == 25) begin
                checks++;
                if ((k == 11 ? key_press[3:2] : key_release[3:2]) !== 2'b11) begin
                    errors++;
                    $display("FAIL simul_pulse cyc=%0d: got press=%b release=%b expected both channels", k,
                             key_press[3:2], key_release[3:2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0000", {key_level, key_press, key_release, key_long});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL reset_mid_model cyc=%0d: got %h expected %h", k,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
            if (k == 11) begin
                checks++;
                if (key_press[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_requalify: got %b expected 1", key_press[0]);
                end
            end
        end
    endtask

    task automatic test_long();
        int longs = 0;
        int long_at = -1;
        key_in[0] = 1'b1;
        repeat (20) tick();
        key_in[0] = 1'b0;
        for (int k = 1; k <= 71; k++) begin
            tick();
            if (key_long[0]) begin longs++; long_at = k; end
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL long_model cyc=%0d: got %h expected %h", k,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
        end
        checks++;
`ifdef KEY_LONGPRESS_EN
        if (longs !== 1 || long_at !== 51) begin
            errors++;
            $display("FAIL long_pulse: got count=%0d at=%0d expected 1 at 51", longs, long_at);
        end
`else
        if (longs !== 0) begin
            errors++;
            $display("FAIL long_disabled: got count=%0d expected 0", longs);
        end
`endif
        key_in[0] = 1'b1;
        repeat (20) tick();
        key_in[0] = 1'b0;
        longs = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 31) key_in[0] = 1'b1;
            tick();
            longs += int'(key_long[0]);
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL short_model cyc=%0d: got %h expected %h", k,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
        end
        checks++;
        if (longs !== 0) begin
            errors++;
            $display("FAIL short_hold_long: got count=%0d expected 0", longs);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(0, 99) < 7) key_in[i] = ~key_in[i];
            end
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL random_model cyc=%0d: got %h expected %h", c,
                         {key_level, key_press, key_release, key_long}, {m_level, m_press, m_rel, m_long});
            end
            checks++;
            if ((key_press & key_release) !== 4'h0) begin
                errors++;
                $display("FAIL random_exclusive cyc=%0d: got press=%b release=%b expected disjoint", c,
                         key_press, key_release);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_long();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
